// File: rtl/mem_arb_rr_pkg.sv
// Shared types for the cache-miss memory arbiter.
// FSM state encodings and priority-mode selectors.
package mem_arb_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_RD   = 2'd2,
    ST_DONE = 2'd3
  } arb_st_e;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational channel picker: rotating search from ptr,
// or lowest-index-wins when fixed is set.
module mem_arb_rr_pick #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              fixed,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = fixed ? i : int'(ptr) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/mem_arb_rr.sv
// N-channel miss arbiter in front of the unified memory:
// optional dirty write-back, then line fill, then one-cycle ack.
module mem_arb_rr
  import mem_arb_rr_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 14,
  parameter int LINE_W    = 64,
  parameter int PRIO_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH-1:0]          wb,
  input  logic [NUM_CH*ADDR_W-1:0]   wb_addr,
  input  logic [NUM_CH*LINE_W-1:0]   wb_data,
  input  logic [NUM_CH*ADDR_W-1:0]   rd_addr,
  output logic [NUM_CH-1:0]          ack,
  output logic [LINE_W-1:0]          rd_data,
  output logic                       busy,
  output logic                       mem_re,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [LINE_W-1:0]          mem_wdata,
  input  logic [LINE_W-1:0]          mem_rdata,
  input  logic                       mem_rdy
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam bit FIXED = (PRIO_MODE == PRIO_FIXED);

  arb_st_e st_q, st_d;

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  g_q, g_d;
  logic [NUM_CH-1:0] goh_q, goh_d;
  logic [ADDR_W-1:0] rda_q, rda_d;

  logic [NUM_CH-1:0] pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  logic [NUM_CH-1:0] ack_d;
  logic [LINE_W-1:0] rd_data_d;
  logic              busy_d;
  logic              re_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [LINE_W-1:0] wdata_d;

  mem_arb_rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .fixed (1'(FIXED)),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    st_d      = st_q;
    ptr_d     = ptr_q;
    g_d       = g_q;
    goh_d     = goh_q;
    rda_d     = rda_q;
    ack_d     = '0;
    rd_data_d = '0;
    re_d      = mem_re;
    we_d      = mem_we;
    addr_d    = mem_addr;
    wdata_d   = mem_wdata;
    unique case (st_q)
      ST_IDLE: begin
        if (pick_any) begin
          g_d   = pick_idx;
          goh_d = pick_oh;
          rda_d = rd_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          if (wb[pick_idx]) begin
            st_d    = ST_WB;
            we_d    = 1'b1;
            addr_d  = wb_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            wdata_d = wb_data[int'(pick_idx)*LINE_W +: LINE_W];
          end else begin
            st_d   = ST_RD;
            re_d   = 1'b1;
            addr_d = rd_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          end
        end
      end
      ST_WB: begin
        if (mem_rdy) begin
          st_d    = ST_RD;
          we_d    = 1'b0;
          re_d    = 1'b1;
          addr_d  = rda_q;
          wdata_d = '0;
        end
      end
      ST_RD: begin
        if (mem_rdy) begin
          st_d      = ST_DONE;
          re_d      = 1'b0;
          addr_d    = '0;
          ack_d     = goh_q;
          rd_data_d = mem_rdata;
        end
      end
      ST_DONE: begin
        st_d = ST_IDLE;
        // Next search starts just past the channel we served.
        if (!FIXED) begin
          ptr_d = (int'(g_q) == NUM_CH - 1) ? '0 : g_q + IDX_W'(1);
        end
      end
      default: st_d = ST_IDLE;
    endcase
    busy_d = (st_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= ST_IDLE;
      ptr_q     <= '0;
      g_q       <= '0;
      goh_q     <= '0;
      rda_q     <= '0;
      ack       <= '0;
      rd_data   <= '0;
      busy      <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      st_q      <= st_d;
      ptr_q     <= ptr_d;
      g_q       <= g_d;
      goh_q     <= goh_d;
      rda_q     <= rda_d;
      ack       <= ack_d;
      rd_data   <= rd_data_d;
      busy      <= busy_d;
      mem_re    <= re_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arb_rr.sv
// Directed bench: 4-channel round-robin and 2-channel fixed-priority
// arbiters, each with a simple latency-programmable memory model.
module tb_mem_arb_rr;

  localparam int AW = 14;
  localparam int LW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]      req[2];
  logic [3:0]      wb[2];
  logic [4*AW-1:0] wb_addr[2];
  logic [4*AW-1:0] rd_addr[2];
  logic [4*LW-1:0] wb_data[2];
  logic [3:0]      ack_a;
  logic [1:0]      ack_b;
  logic [LW-1:0]   rdd[2];
  logic            busy[2];
  logic            mre[2];
  logic            mwe[2];
  logic            mrdy[2];
  logic [AW-1:0]   maddr[2];
  logic [LW-1:0]   mwdata[2];
  logic [LW-1:0]   mrdata[2];

  mem_arb_rr #(
    .NUM_CH(4), .ADDR_W(AW), .LINE_W(LW), .PRIO_MODE(0)
  ) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req(req[0]), .wb(wb[0]),
    .wb_addr(wb_addr[0]), .wb_data(wb_data[0]),
    .rd_addr(rd_addr[0]),
    .ack(ack_a), .rd_data(rdd[0]), .busy(busy[0]),
    .mem_re(mre[0]), .mem_we(mwe[0]),
    .mem_addr(maddr[0]), .mem_wdata(mwdata[0]),
    .mem_rdata(mrdata[0]), .mem_rdy(mrdy[0])
  );

  mem_arb_rr #(
    .NUM_CH(2), .ADDR_W(AW), .LINE_W(LW), .PRIO_MODE(1)
  ) u_fx (
    .clk(clk), .rst_n(rst_n),
    .req(req[1][1:0]), .wb(wb[1][1:0]),
    .wb_addr(wb_addr[1][2*AW-1:0]), .wb_data(wb_data[1][2*LW-1:0]),
    .rd_addr(rd_addr[1][2*AW-1:0]),
    .ack(ack_b), .rd_data(rdd[1]), .busy(busy[1]),
    .mem_re(mre[1]), .mem_we(mwe[1]),
    .mem_addr(maddr[1]), .mem_wdata(mwdata[1]),
    .mem_rdata(mrdata[1]), .mem_rdy(mrdy[1])
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] line_of(input logic [AW-1:0] a);
    if (a == 14'h0010) return 64'hDEAD_BEEF_0000_1234;
    return {4{2'b10, a}};
  endfunction

  function automatic logic [3:0] ackv(input int k);
    return (k == 0) ? ack_a : {2'b00, ack_b};
  endfunction

  // memory model: mem_rdy mdly cycles after the strobe is first seen
  int            mdly[2];
  int            cnt[2];
  bit            stray[2];
  int            wcnt[2];
  int            both[2];
  logic [AW-1:0] wl_addr[2];
  logic [LW-1:0] wl_data[2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mrdy[k] = 1'b0;
      if (mre[k] && mwe[k]) both[k]++;
      if (!rst_n) begin
        cnt[k] = 0;
      end else if (mre[k] || mwe[k]) begin
        if (cnt[k] >= mdly[k]) begin
          mrdy[k]   = 1'b1;
          cnt[k]    = 0;
          mrdata[k] = line_of(maddr[k]);
          if (mwe[k]) begin
            wcnt[k]++;
            wl_addr[k] = maddr[k];
            wl_data[k] = mwdata[k];
          end
        end else begin
          cnt[k]++;
        end
      end else begin
        cnt[k] = 0;
        if (stray[k]) begin
          mrdy[k]  = 1'b1;
          stray[k] = 1'b0;
        end
      end
    end
  end

  // requesters: hold req while requests pend, log every ack
  int         pend[2][4];
  int         glog0[$];
  int         glog1[$];
  int         nack[2];
  logic [3:0] av;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      av = ackv(k);
      if (rst_n && av != 4'd0) begin
        nack[k]++;
        chk("ack_onehot", 64'($countones(av)), 64'd1);
        for (int c = 0; c < 4; c++) begin
          if (av[c]) begin
            if (k == 0) glog0.push_back(c);
            else glog1.push_back(c);
            chk("rd_data", rdd[k], line_of(rd_addr[k][c*AW +: AW]));
            if (pend[k][c] > 0) pend[k][c]--;
            req[k][c] = (pend[k][c] != 0);
          end
        end
      end
    end
  end

  function automatic int gl(input int k, input int i);
    if (k == 0) return (i < glog0.size()) ? glog0[i] : -1;
    return (i < glog1.size()) ? glog1[i] : -1;
  endfunction

  task automatic request(input int k, input int c, input int n);
    pend[k][c] += n;
    req[k][c] = 1'b1;
  endtask

  task automatic clear_req();
    for (int k = 0; k < 2; k++) begin
      req[k] = '0;
      for (int c = 0; c < 4; c++) pend[k][c] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_req();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int k, input int budget);
    bit done;
    int sum;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      sum = 0;
      for (int c = 0; c < 4; c++) sum += pend[k][c];
      if (sum == 0 && !busy[k]) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  // single request; latency counted from the IDLE cycle that sees req
  task automatic run(input int k, input int c, input int dly,
                     output int lat, output logic [AW-1:0] ra);
    bit         got_ra;
    logic [3:0] a;
    mdly[k] = dly;
    @(negedge clk);
    request(k, c, 1);
    lat    = 0;
    ra     = '0;
    got_ra = 1'b0;
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      @(negedge clk);
      if (mre[k] && !got_ra) begin
        ra     = maddr[k];
        got_ra = 1'b1;
      end
      a = ackv(k);
      if (a[c]) lat = n + 1;
    end
    @(negedge clk);
  endtask

  int            lat;
  logic [AW-1:0] ra;
  int            w0;
  int            a0;
  bit            seen;

  initial begin
    for (int k = 0; k < 2; k++) begin
      wb[k]      = '0;
      wb_addr[k] = '0;
      wb_data[k] = '0;
      rd_addr[k] = '0;
      mdly[k]    = 0;
      cnt[k]     = 0;
      stray[k]   = 1'b0;
      wcnt[k]    = 0;
      both[k]    = 0;
      nack[k]    = 0;
      mrdy[k]    = 1'b0;
      mrdata[k]  = '0;
    end
    clear_req();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", 64'(busy[k]), 64'd0);
      chk("rst_re", 64'(mre[k]), 64'd0);
      chk("rst_we", 64'(mwe[k]), 64'd0);
      chk("rst_addr", 64'(maddr[k]), 64'd0);
      chk("rst_wdata", mwdata[k], 64'd0);
      chk("rst_rdata", rdd[k], 64'd0);
    end
    chk("rst_ack_a", 64'(ack_a), 64'd0);
    chk("rst_ack_b", 64'(ack_b), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single fill, slow memory
    rd_addr[0][0 +: AW] = 14'h0010;
    run(0, 0, 4, lat, ra);
    chk("fill_lat", 64'(lat), 64'd7);
    chk("fill_addr", 64'(ra), 64'h10);
    chk("fill_grant", 64'(gl(0, 0)), 64'd0);

    // write-back then fill on ch1
    wb[0][1]             = 1'b1;
    wb_addr[0][AW +: AW] = 14'h0020;
    wb_data[0][LW +: LW] = 64'h0123_4567_89AB_CDEF;
    rd_addr[0][AW +: AW] = 14'h0030;
    w0 = wcnt[0];
    a0 = nack[0];
    run(0, 1, 0, lat, ra);
    chk("wb_lat", 64'(lat), 64'd4);
    chk("wb_rd_addr", 64'(ra), 64'h30);
    chk("wb_count", 64'(wcnt[0] - w0), 64'd1);
    chk("wb_addr", 64'(wl_addr[0]), 64'h20);
    chk("wb_data", wl_data[0], 64'h0123_4567_89AB_CDEF);
    repeat (2) @(negedge clk);
    chk("wb_acks", 64'(nack[0] - a0), 64'd1);
    chk("wb_grant", 64'(gl(0, 1)), 64'd1);
    wb[0][1] = 1'b0;

    // round-robin contention
    for (int c = 0; c < 4; c++) rd_addr[0][c*AW +: AW] = AW'(14'h100 + c);
    do_reset();
    glog0.delete();
    @(negedge clk);
    request(0, 0, 1);
    request(0, 1, 1);
    drain(0, 100);
    chk("rr_n", 64'(glog0.size()), 64'd2);
    chk("rr_g0", 64'(gl(0, 0)), 64'd0);
    chk("rr_g1", 64'(gl(0, 1)), 64'd1);
    glog0.delete();
    request(0, 0, 2);
    request(0, 1, 1);
    drain(0, 100);
    chk("rr2_g0", 64'(gl(0, 0)), 64'd0);
    chk("rr2_g1", 64'(gl(0, 1)), 64'd1);
    chk("rr2_g2", 64'(gl(0, 2)), 64'd0);

    // fixed priority: ch0 keeps re-requesting
    rd_addr[1][0 +: AW]  = 14'h0200;
    rd_addr[1][AW +: AW] = 14'h0201;
    glog1.delete();
    request(1, 0, 3);
    request(1, 1, 1);
    drain(1, 100);
    chk("fx_n", 64'(glog1.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fx_g%0d", i), 64'(gl(1, i)), (i == 3) ? 64'd1 : 64'd0);
    end

    // reset while RD is stalled
    rd_addr[0][2*AW +: AW] = 14'h0044;
    mdly[0] = 6;
    @(negedge clk);
    request(0, 2, 1);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (mre[0]) seen = 1'b1;
    end
    chk("rd_started", 64'(seen), 64'd1);
    @(negedge clk);
    a0 = nack[0];
    rst_n = 1'b0;
    clear_req();
    #1;
    chk("mid_rst_busy", 64'(busy[0]), 64'd0);
    chk("mid_rst_re", 64'(mre[0]), 64'd0);
    chk("mid_rst_addr", 64'(maddr[0]), 64'd0);
    chk("mid_rst_ack", 64'(ack_a), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_noack", 64'(nack[0] - a0), 64'd0);
    glog0.delete();
    run(0, 2, 0, lat, ra);
    chk("post_rst_lat", 64'(lat), 64'd3);
    chk("post_rst_addr", 64'(ra), 64'h44);
    chk("post_rst_grant", 64'(gl(0, 0)), 64'd2);

    // all four channels, two requests each
    do_reset();
    glog0.delete();
    @(negedge clk);
    for (int c = 0; c < 4; c++) request(0, c, 2);
    drain(0, 200);
    chk("rr4_n", 64'(glog0.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr4_g%0d", i), 64'(gl(0, i)), 64'(i % 4));
    end

    // stray mem_rdy while idle
    a0 = nack[0];
    stray[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_busy", 64'(busy[0]), 64'd0);
    chk("stray_re", 64'(mre[0]), 64'd0);
    chk("stray_we", 64'(mwe[0]), 64'd0);
    chk("stray_ack", 64'(nack[0] - a0), 64'd0);
    run(0, 3, 0, lat, ra);
    chk("stray_next_lat", 64'(lat), 64'd3);

    chk("both_strobes", 64'(both[0] + both[1]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
